// File: rtl/switch_debounce_strobe.sv
// switch_debounce_strobe: debounces a bouncy level into d_out plus one-cycle change strobes.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer ahead of the debouncer.
module switch_debounce_strobe #(
   parameter int CNT_MAX = 4,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic d_out,
   output logic en_pulse,
   output logic rise,
   output logic fall,
   output logic busy
);
   typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;
   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              w_s, w_last, w_rise, w_fall;
`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] r_sync;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[0], din};
   assign w_s = r_sync[1];
`else
   assign w_s = din;
`endif
   assign w_last = r_cnt == CNT_W'(CNT_MAX - 1);
   always_comb begin
      w_next = r_state;
      w_cnt  = '0;
      w_rise = 1'b0;
      w_fall = 1'b0;
      case (r_state)
         LOW:   w_next = w_s ? CHK_H : LOW;
         HIGH:  w_next = w_s ? HIGH : CHK_L;
         CHK_H: begin
            w_next = !w_s ? LOW : w_last ? HIGH : CHK_H;
            w_rise = w_s && w_last;
            w_cnt  = (w_s && !w_last) ? r_cnt + 1'b1 : '0;
         end
         default: begin
            w_next = w_s ? HIGH : w_last ? LOW : CHK_L;
            w_fall = !w_s && w_last;
            w_cnt  = (!w_s && !w_last) ? r_cnt + 1'b1 : '0;
         end
      endcase
   end
   // outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state  <= LOW;
         r_cnt    <= '0;
         d_out    <= 1'b0;
         en_pulse <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt;
         d_out    <= w_next == HIGH || w_next == CHK_L;
         en_pulse <= w_rise | w_fall;
         rise     <= w_rise;
         fall     <= w_fall;
         busy     <= w_next == CHK_H || w_next == CHK_L;
      end
endmodule

// File: tb/tb_switch_debounce_strobe.sv
// tb_switch_debounce_strobe: random and directed stimulus against a run-length debounce model.
module tb_switch_debounce_strobe;
   localparam int CNT_MAX = 4;
`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = CNT_MAX + SYNC;
   logic clk = 1'b0, rst = 1'b0, din = 1'b0;
   logic d_out, en_pulse, rise, fall, busy;
   int checks = 0, errors = 0;
   switch_debounce_strobe #(.CNT_MAX(CNT_MAX), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .d_out(d_out),
      .en_pulse(en_pulse), .rise(rise), .fall(fall), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // model: level flips once the sample has disagreed with it CNT_MAX+1 edges in a row
   logic       m_lvl, m_rise, m_fall;
   int         m_run;
   logic [1:0] m_hist;
   always @(posedge clk or negedge rst) begin : model
      logic s;
      int   r;
      if (!rst) begin
         m_lvl <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0; m_hist <= 2'b00;
      end else begin
         s = (SYNC == 2) ? m_hist[1] : din;
         m_hist <= {m_hist[0], din};
         r = (s != m_lvl) ? m_run + 1 : 0;
         m_rise <= (r > CNT_MAX) && s;
         m_fall <= (r > CNT_MAX) && !s;
         if (r > CNT_MAX) begin
            m_lvl <= s;
            r = 0;
         end
         m_run <= r;
      end
   end
   always @(negedge clk)
      if (rst) begin
         chk("d_out", d_out, m_lvl);
         chk("en_pulse", en_pulse, m_rise | m_fall);
         chk("rise", rise, m_rise);
         chk("fall", fall, m_fall);
         chk("busy", busy, m_run > 0);
      end
   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_d_out", d_out, 1'b0);
      chk("rst_en", en_pulse, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      chk("rst_busy", busy, 1'b0);
      din = 1'b1;
      repeat (LAT) tick();
      chk("rise_early", d_out, 1'b0);
      chk("rise_busy", busy, 1'b1);
      tick();
      chk("rise_d_out", d_out, 1'b1);
      chk("rise_strobe", rise, 1'b1);
      chk("rise_en", en_pulse, 1'b1);
      chk("rise_nofall", fall, 1'b0);
      tick();
      chk("rise_once", rise, 1'b0);
      chk("rise_en_once", en_pulse, 1'b0);
      din = 1'b0;
      repeat (3) tick();
      din = 1'b1;
      repeat (LAT + 2) tick();
      chk("glitch_fall", d_out, 1'b1);
      chk("glitch_fall_busy", busy, 1'b0);
      din = 1'b0;
      repeat (LAT) tick();
      chk("fall_early", d_out, 1'b1);
      tick();
      chk("fall_d_out", d_out, 1'b0);
      chk("fall_strobe", fall, 1'b1);
      chk("fall_en", en_pulse, 1'b1);
      tick();
      chk("fall_once", fall, 1'b0);
      din = 1'b1;
      repeat (3) tick();
      din = 1'b0;
      repeat (LAT + 2) tick();
      chk("glitch_rise", d_out, 1'b0);
      chk("glitch_rise_busy", busy, 1'b0);
      din = 1'b1;
      repeat (SYNC + 2) tick();
      chk("mid_busy", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_d_out", d_out, 1'b0);
      chk("mid_rst_en", en_pulse, 1'b0);
      rst = 1'b1;
      repeat (LAT) tick();
      chk("requal_early", d_out, 1'b0);
      tick();
      chk("requal_d_out", d_out, 1'b1);
      repeat (20) tick();
      chk("hold_no_strobe", en_pulse, 1'b0);
      repeat (80) begin
         din = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, LAT + 3)) begin
            tick();
            if ($urandom_range(0, 39) == 0) begin
               rst = 1'b0;
               #1 rst = 1'b1;
            end
         end
      end
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_debounce_strobe.md
Name: switch_debounce_strobe

Overview:
Upstream conditioning stage for the enabled D flip-flop. Takes a raw, bouncy level input (switch or button) and produces a debounced level `d_out` for the flop's D input. It also produces a one-cycle strobe `en_pulse` for the flop's enable input, so the flop captures only on a validated level change. Edge flags `rise` and `fall` are provided for other consumers.

Parameters:
- CNT_MAX, 4, number of consecutive agreeing samples required after the first differing sample before the output changes; legal range 1..2^CNT_W.
- CNT_W, 8, stability counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  1  raw level input; may bounce.
- d_out  output  1  debounced level; drives the downstream flop's D.
- en_pulse  output  1  one-cycle strobe on any validated change of d_out; drives the downstream flop's enable.
- rise  output  1  one-cycle strobe on a validated 0->1 change.
- fall  output  1  one-cycle strobe on a validated 1->0 change.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-low.
- Reset values (rst=0): state=LOW, cnt=0, d_out=0, en_pulse=0, rise=0, fall=0, busy=0. Synchronizer flops (if present) are also 0. Reset takes effect immediately, without waiting for `clk`.
- Sample signal `s`: `din` sampled at each rising edge, or the synchronizer output when the optional feature is compiled in.
- All outputs are registered.
- FSM has four states: LOW, CHK_H, HIGH, CHK_L.
  - LOW: d_out=0. If s=1, go to CHK_H with cnt<=0. Otherwise stay.
  - CHK_H:
    - If s=0, return to LOW, cnt<=0, no strobe (glitch rejected).
    - Else if cnt==CNT_MAX-1, go to HIGH; d_out<=1; en_pulse<=1 and rise<=1 for exactly one cycle.
    - Else cnt<=cnt+1.
  - HIGH: mirror of LOW. If s=0, go to CHK_L with cnt<=0.
  - CHK_L: mirror of CHK_H.
    - If s=1, return to HIGH with no strobe.
    - On cnt==CNT_MAX-1, go to LOW; d_out<=0; en_pulse<=1 and fall<=1 for one cycle.
- Latency (no sync): if s first reads 1 at edge n and stays 1 through edge n+CNT_MAX, then d_out=1 and the strobes are asserted after edge n+CNT_MAX. This requires CNT_MAX+1 consecutive agreeing samples.
- busy=1 exactly while state is CHK_H or CHK_L.
- Strobes:
  - en_pulse = rise | fall.
  - rise and fall are never high together.
  - Strobes deassert on the next edge, even if another transition begins in that cycle.
- Counter: cnt never exceeds CNT_MAX-1 and never wraps. It is held at 0 in LOW and HIGH.
- Abort on disagreement: a disagreeing sample on the final count edge (cnt==CNT_MAX-1 with s reverting) aborts; no transition occurs.
- Reset mid-qualification: asserting rst while in CHK_H or CHK_L aborts the qualification with no strobe. After release, the block resumes in LOW.
- Input held constant: if din is held at the current d_out level, no strobes are ever produced.

Optional Feature:
Macro: DEBOUNCE_SYNC_EN.
- Defined: a two-flop synchronizer (reset to 0 by rst) sits between `din` and `s`. All latencies increase by 2 cycles. This is the required configuration when `din` is asynchronous to `clk`.
- Undefined: `s` is `din` sampled directly at the clock edge. This is for inputs already synchronous to `clk`.
- FSM behaviour is identical in both builds.

Test Plan:
1. Reset check: rst=0 for 1 ns, then release -> d_out=0, en_pulse=0, rise=0, fall=0, busy=0 before the first clk edge.
2. Clean rise (CNT_MAX=4, no sync): din=1 held from edge n -> busy=1 after edges n..n+3; d_out=1 after edge n+4; en_pulse=rise=1 for one cycle only; fall stays 0.
3. Glitch reject: din=1 for 3 edges, then 0 -> d_out stays 0; en_pulse never asserts; busy high for 3 cycles, then 0.
4. Clean fall from HIGH: din=0 for 5 edges -> d_out=0 after the 5th edge; en_pulse=fall=1 for one cycle.
5. Reset mid-CHK_H: din=1 for 2 edges, then assert rst -> busy=0 and cnt=0 immediately. After release with din=1, a full 5 samples are again required before d_out=1.
6. DEBOUNCE_SYNC_EN build: repeat scenario 2 -> d_out rises after edge n+6; strobe is one cycle; fed into the downstream flop's D and enable, the flop's q=1 on the same edge at which en_pulse is first sampled high.
